if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction-fetch stage with a prefetch queue. It owns the fetch PC and issues one outstanding request at a time to the icache/memory controller.
- Returned instructions are buffered with their PC in a QDEPTH-entry circular queue, which drains to the IF/ID stage through a valid/ready handshake.
- Handles branch-redirect flushes, including discarding an in-flight icache response.

Parameters:
ADDR_W, 32, PC/address width
INST_W, 32, instruction width
QDEPTH, 4, queue entries; power of two, >=2
RESET_PC, 0, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
flush_in  in  1  redirect from EX/branch unit
flush_pc_in  in  ADDR_W  new fetch PC when flush_in=1
ic_req_out  out  1  fetch request to icache, level, held until response
ic_addr_out  out  ADDR_W  request address, stable while ic_req_out=1
ic_valid_in  in  1  icache response valid, single-cycle pulse
ic_inst_in  in  INST_W  response instruction
id_ready_in  in  1  IF/ID accepts head entry
id_valid_out  out  1  head entry valid
id_pc_out  out  ADDR_W  head entry PC
id_inst_out  out  INST_W  head entry instruction
stall_or_not  out  1  to stall control; 1 when queue empty (ID bubble)

Behaviour:
- Reset (rst=1 at posedge): fetch_pc=RESET_PC, state=IDLE, count=0, head=tail=0. All outputs read 0: ic_req_out, ic_addr_out, id_valid_out, id_pc_out, id_inst_out. stall_or_not=1. rst overrides flush and responses; a reset mid-request drops the request, and a later ic_valid_in is ignored because state is IDLE.
- States: IDLE, WAIT, DROP.
  - IDLE: if count<QDEPTH and !flush_in, then next cycle ic_req_out=1, ic_addr_out=fetch_pc, state WAIT.
  - WAIT: hold request. On ic_valid_in: push {fetch_pc, ic_inst_in} at tail, fetch_pc+=4 (mod 2^ADDR_W), state IDLE, ic_req_out=0 next cycle.
  - DROP: ic_req_out=0. Wait for ic_valid_in, discard the data, state IDLE.
- Throughput: one instruction per 2 cycles minimum (request cycle, then response). A response in the first WAIT cycle is legal.
- Request issue condition is count<QDEPTH, evaluated in IDLE, so a push never overflows. ic_valid_in in IDLE is ignored.
- Dequeue: id_valid_out=(count!=0). id_pc_out/id_inst_out show the head entry, or 0 when empty. Pop when id_valid_out && id_ready_in && !flush_in.
- Push and pop in the same cycle: count unchanged; head and tail both advance, wrapping modulo QDEPTH.
- flush_in (highest priority after rst): count=0, head=tail=0, fetch_pc=flush_pc_in. Any pop or push that cycle is cancelled. State transitions on flush:
  - IDLE -> IDLE.
  - WAIT with no ic_valid_in -> DROP.
  - WAIT with ic_valid_in the same cycle -> IDLE, response discarded.
  - DROP -> DROP, or IDLE if ic_valid_in.
  - The first request to flush_pc_in is issued at the earliest in the cycle after flush.
- stall_or_not = (count==0), combinational from registered count.

Optional Feature:
- Macro: IF_JAL_PREDECODE_EN.
- Defined: on a WAIT response with ic_inst_in[6:0]==7'b1101111 (JAL), fetch_pc <= fetch_pc + sign-extended J-immediate {inst[31],inst[19:12],inst[20],inst[30:21],1'b0} instead of +4. The entry is still pushed. Flush still overrides.
- Undefined: always +4; no decode logic is synthesised.

Decomposition:
- Shared package/defines: ADDR_W/INST_W defaults, OPC_JAL constant, fetch state encoding (IDLE=2'd0, WAIT=2'd1, DROP=2'd2), zero-word constant.
- Sub-module: if_fetch_fifo, a parametrised circular buffer of {pc, inst} with push/pop/clear, count, and full/empty outputs. The FSM and PC logic stay in the top.

Test Plan:
- Reset, id_ready_in=1, icache answers 1 cycle after each request: ic_addr_out sequence 0x0,0x4,0x8. id outputs match {pc,inst} pairs in order. stall_or_not=1 until the first push.
- id_ready_in=0, QDEPTH=4: exactly 4 responses accepted (PCs 0x0–0xC), ic_req_out stays 0 while count=4. Raising id_ready_in for 1 cycle pops 0x0, then a request to 0x10 issues.
- Flush to 0x100 while in WAIT for 0x8: queue empties next cycle, stale response (0xDEADBEEF) 3 cycles later is not enqueued, next ic_addr_out=0x100.
- Flush coincident with ic_valid_in and an id pop: no push, no pop, count=0, next request 0x200=flush_pc_in.
- Simultaneous push and pop over 2*QDEPTH cycles with wrap-around: count constant, FIFO order preserved across the index wrap.
- IF_JAL_PREDECODE_EN: response at PC 0x10 is JAL +0x20 (0x0200006F) -> next ic_addr_out=0x30. Without the macro -> 0x14.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and fetch state encoding for the instruction-fetch queue.
package if_fetch_queue_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned INST_W_DEF = 32;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_t;

endpackage : if_fetch_queue_pkg

// File: rtl/if_fetch_fifo.sv
// Circular buffer of {pc, inst} entries with push/pop/clear, count and full/empty.
module if_fetch_fifo #(
   parameter int unsigned AW    = 32,
   parameter int unsigned IW    = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         push,
   input  logic [AW-1:0]                push_pc,
   input  logic [IW-1:0]                push_inst,
   input  logic                         pop,
   output logic [AW-1:0]                head_pc,
   output logic [IW-1:0]                head_inst,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         full,
   output logic                         empty
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam int unsigned ENT_W = AW + IW;

   logic [ENT_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] tail;
   logic [ENT_W-1:0] head_entry;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // Indices wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_ok) tail <= tail + IDX_W'(1);
         if (pop_ok)  head <= head + IDX_W'(1);
         if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
         else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !clear && push_ok) mem[tail] <= {push_pc, push_inst};
   end

   assign head_entry = mem[head];
   assign head_pc    = empty ? '0 : head_entry[ENT_W-1:IW];
   assign head_inst  = empty ? '0 : head_entry[IW-1:0];

endmodule : if_fetch_fifo

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: single-outstanding icache requester feeding a prefetch queue.
// Optional JAL target predecode is enabled by defining IF_JAL_PREDECODE_EN.
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ADDR_W_DEF,
   parameter int unsigned       INST_W   = INST_W_DEF,
   parameter int unsigned       QDEPTH   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_in,
   input  logic [ADDR_W-1:0] flush_pc_in,
   output logic              ic_req_out,
   output logic [ADDR_W-1:0] ic_addr_out,
   input  logic              ic_valid_in,
   input  logic [INST_W-1:0] ic_inst_in,
   input  logic              id_ready_in,
   output logic              id_valid_out,
   output logic [ADDR_W-1:0] id_pc_out,
   output logic [INST_W-1:0] id_inst_out,
   output logic              stall_or_not
);

   localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

   fetch_state_t      state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] next_pc_c;
   logic [CNT_W-1:0]  q_count;
   logic              q_full;
   logic              q_empty;
   logic              push_c;
   logic              pop_c;

   assign push_c = (state == ST_WAIT) && ic_valid_in && !flush_in;
   assign pop_c  = !q_empty && id_ready_in && !flush_in;

`ifdef IF_JAL_PREDECODE_EN
   logic [20:0] j_imm_c;
   assign j_imm_c = {ic_inst_in[31], ic_inst_in[19:12], ic_inst_in[20], ic_inst_in[30:21], 1'b0};

   // Follow unconditional jumps straight away instead of fetching the fall-through.
   always_comb begin
      next_pc_c = fetch_pc + ADDR_W'(4);
      if (ic_inst_in[6:0] == OPC_JAL)
         next_pc_c = fetch_pc + {{(ADDR_W-21){j_imm_c[20]}}, j_imm_c};
   end
`else
   assign next_pc_c = fetch_pc + ADDR_W'(4);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         fetch_pc    <= RESET_PC;
         ic_req_out  <= 1'b0;
         ic_addr_out <= ADDR_W'(ZERO_WORD);
      end else if (flush_in) begin
         // An unanswered request must still have its response swallowed.
         fetch_pc   <= flush_pc_in;
         ic_req_out <= 1'b0;
         case (state)
            ST_WAIT: state <= ic_valid_in ? ST_IDLE : ST_DROP;
            ST_DROP: state <= ic_valid_in ? ST_IDLE : ST_DROP;
            default: state <= ST_IDLE;
         endcase
      end else begin
         case (state)
            ST_IDLE: begin
               if (!q_full) begin
                  ic_req_out  <= 1'b1;
                  ic_addr_out <= fetch_pc;
                  state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (ic_valid_in) begin
                  ic_req_out <= 1'b0;
                  fetch_pc   <= next_pc_c;
                  state      <= ST_IDLE;
               end
            end
            ST_DROP: begin
               ic_req_out <= 1'b0;
               if (ic_valid_in) state <= ST_IDLE;
            end
            default: begin
               ic_req_out <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

   if_fetch_fifo #(
      .AW    (ADDR_W),
      .IW    (INST_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush_in),
      .push      (push_c),
      .push_pc   (fetch_pc),
      .push_inst (ic_inst_in),
      .pop       (pop_c),
      .head_pc   (id_pc_out),
      .head_inst (id_inst_out),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   assign id_valid_out = !q_empty;
   assign stall_or_not = (q_count == '0);

endmodule : if_fetch_queue

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue (QDEPTH=4, RESET_PC=0).
module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_in;
   logic [31:0] flush_pc_in;
   logic        ic_req_out;
   logic [31:0] ic_addr_out;
   logic        ic_valid_in;
   logic [31:0] ic_inst_in;
   logic        id_ready_in;
   logic        id_valid_out;
   logic [31:0] id_pc_out;
   logic [31:0] id_inst_out;
   logic        stall_or_not;

   int checks = 0;
   int errors = 0;

   if_fetch_queue #(
      .ADDR_W   (32),
      .INST_W   (32),
      .QDEPTH   (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush_in     (flush_in),
      .flush_pc_in  (flush_pc_in),
      .ic_req_out   (ic_req_out),
      .ic_addr_out  (ic_addr_out),
      .ic_valid_in  (ic_valid_in),
      .ic_inst_in   (ic_inst_in),
      .id_ready_in  (id_ready_in),
      .id_valid_out (id_valid_out),
      .id_pc_out    (id_pc_out),
      .id_inst_out  (id_inst_out),
      .stall_or_not (stall_or_not)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return 32'hC0DE_0000 | {16'h0, a[15:0]};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; flush_in = 1'b0; flush_pc_in = '0;
      ic_valid_in = 1'b0; ic_inst_in = '0; id_ready_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Answer n consecutive requests starting at PC 0 with id_ready_in low.
   task automatic fill(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         ic_valid_in = 1'b1; ic_inst_in = inst_of(32'(4*k));
         @(negedge clk);
         ic_valid_in = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; flush_in = 1'b0; flush_pc_in = '0;
      ic_valid_in = 1'b0; ic_inst_in = '0; id_ready_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (ic_req_out !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", ic_req_out); end
      checks++; if (ic_addr_out !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", ic_addr_out); end
      checks++; if (id_valid_out !== 1'b0) begin errors++; $display("FAIL rst_idv got %0b exp 0", id_valid_out); end
      checks++; if (id_pc_out !== 32'h0 || id_inst_out !== 32'h0) begin errors++; $display("FAIL rst_id got %h/%h exp 0/0", id_pc_out, id_inst_out); end
      checks++; if (stall_or_not !== 1'b1) begin errors++; $display("FAIL rst_stall got %0b exp 1", stall_or_not); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (ic_req_out !== 1'b1 || ic_addr_out !== 32'h0) begin errors++; $display("FAIL rst_first_req got %0b/%h exp 1/0", ic_req_out, ic_addr_out); end
      // Reset mid-request, then a late response while IDLE must be ignored.
      rst = 1'b1;
      @(negedge clk);
      checks++; if (ic_req_out !== 1'b0) begin errors++; $display("FAIL rst_mid_req got %0b exp 0", ic_req_out); end
      rst = 1'b0; ic_valid_in = 1'b1; ic_inst_in = 32'h1111_1111;
      @(negedge clk);
      ic_valid_in = 1'b0;
      checks++; if (id_valid_out !== 1'b0) begin errors++; $display("FAIL rst_late_resp idv got %0b exp 0", id_valid_out); end
      checks++; if (ic_req_out !== 1'b1 || ic_addr_out !== 32'h0) begin errors++; $display("FAIL rst_reissue got %0b/%h exp 1/0", ic_req_out, ic_addr_out); end
   endtask

   task automatic test_stream();
      do_reset();
      id_ready_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (ic_req_out !== 1'b1 || ic_addr_out !== 32'(4*k)) begin errors++; $display("FAIL stream_req%0d got %0b/%h exp 1/%h", k, ic_req_out, ic_addr_out, 32'(4*k)); end
         checks++; if (stall_or_not !== 1'b1) begin errors++; $display("FAIL stream_stall%0d got %0b exp 1", k, stall_or_not); end
         ic_valid_in = 1'b1; ic_inst_in = inst_of(32'(4*k));
         @(negedge clk);
         ic_valid_in = 1'b0;
         checks++; if (id_valid_out !== 1'b1 || id_pc_out !== 32'(4*k) || id_inst_out !== inst_of(32'(4*k)))
            begin errors++; $display("FAIL stream_id%0d got %0b/%h/%h exp 1/%h/%h", k, id_valid_out, id_pc_out, id_inst_out, 32'(4*k), inst_of(32'(4*k))); end
         checks++; if (ic_req_out !== 1'b0 || stall_or_not !== 1'b0) begin errors++; $display("FAIL stream_idle%0d got req %0b stall %0b exp 0/0", k, ic_req_out, stall_or_not); end
      end
   endtask

   task automatic test_full();
      do_reset();
      fill(4);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (ic_req_out !== 1'b0) begin errors++; $display("FAIL full_noreq%0d got %0b exp 0", k, ic_req_out); end
      end
      checks++; if (id_valid_out !== 1'b1 || id_pc_out !== 32'h0) begin errors++; $display("FAIL full_head got %0b/%h exp 1/0", id_valid_out, id_pc_out); end
      id_ready_in = 1'b1;
      @(negedge clk);
      id_ready_in = 1'b0;
      checks++; if (id_pc_out !== 32'h4 || id_inst_out !== inst_of(32'h4)) begin errors++; $display("FAIL full_pop got %h/%h exp 4/%h", id_pc_out, id_inst_out, inst_of(32'h4)); end
      checks++; if (ic_req_out !== 1'b0) begin errors++; $display("FAIL full_req_lag got %0b exp 0", ic_req_out); end
      @(negedge clk);
      checks++; if (ic_req_out !== 1'b1 || ic_addr_out !== 32'h10) begin errors++; $display("FAIL full_next_req got %0b/%h exp 1/10", ic_req_out, ic_addr_out); end
   endtask

   task automatic test_flush_wait();
      do_reset();
      fill(2);
      @(negedge clk);
      checks++; if (ic_req_out !== 1'b1 || ic_addr_out !== 32'h8) begin errors++; $display("FAIL fw_req got %0b/%h exp 1/8", ic_req_out, ic_addr_out); end
      flush_in = 1'b1; flush_pc_in = 32'h100;
      @(negedge clk);
      flush_in = 1'b0;
      checks++; if (id_valid_out !== 1'b0 || stall_or_not !== 1'b1 || ic_req_out !== 1'b0)
         begin errors++; $display("FAIL fw_empty got idv %0b stall %0b req %0b exp 0/1/0", id_valid_out, stall_or_not, ic_req_out); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (ic_req_out !== 1'b0) begin errors++; $display("FAIL fw_drop_req got %0b exp 0", ic_req_out); end
      ic_valid_in = 1'b1; ic_inst_in = 32'hDEAD_BEEF;
      @(negedge clk);
      ic_valid_in = 1'b0;
      checks++; if (id_valid_out !== 1'b0) begin errors++; $display("FAIL fw_stale got idv %0b exp 0", id_valid_out); end
      @(negedge clk);
      checks++; if (ic_req_out !== 1'b1 || ic_addr_out !== 32'h100) begin errors++; $display("FAIL fw_redirect got %0b/%h exp 1/100", ic_req_out, ic_addr_out); end
      ic_valid_in = 1'b1; ic_inst_in = inst_of(32'h100);
      @(negedge clk);
      ic_valid_in = 1'b0;
      checks++; if (id_pc_out !== 32'h100 || id_inst_out !== inst_of(32'h100)) begin errors++; $display("FAIL fw_head got %h/%h exp 100/%h", id_pc_out, id_inst_out, inst_of(32'h100)); end
   endtask

   task automatic test_flush_coincident();
      do_reset();
      fill(1);
      @(negedge clk);
      checks++; if (ic_req_out !== 1'b1 || ic_addr_out !== 32'h4) begin errors++; $display("FAIL fc_req got %0b/%h exp 1/4", ic_req_out, ic_addr_out); end
      ic_valid_in = 1'b1; ic_inst_in = inst_of(32'h4); id_ready_in = 1'b1;
      flush_in = 1'b1; flush_pc_in = 32'h200;
      @(negedge clk);
      ic_valid_in = 1'b0; id_ready_in = 1'b0; flush_in = 1'b0;
      checks++; if (id_valid_out !== 1'b0 || stall_or_not !== 1'b1 || ic_req_out !== 1'b0)
         begin errors++; $display("FAIL fc_state got idv %0b stall %0b req %0b exp 0/1/0", id_valid_out, stall_or_not, ic_req_out); end
      @(negedge clk);
      checks++; if (ic_req_out !== 1'b1 || ic_addr_out !== 32'h200) begin errors++; $display("FAIL fc_redirect got %0b/%h exp 1/200", ic_req_out, ic_addr_out); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      fill(2);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++; if (ic_req_out !== 1'b1 || ic_addr_out !== 32'(8 + 4*i)) begin errors++; $display("FAIL b2b_req%0d got %0b/%h exp 1/%h", i, ic_req_out, ic_addr_out, 32'(8 + 4*i)); end
         ic_valid_in = 1'b1; ic_inst_in = inst_of(32'(8 + 4*i)); id_ready_in = 1'b1;
         @(negedge clk);
         ic_valid_in = 1'b0; id_ready_in = 1'b0;
         checks++; if (id_valid_out !== 1'b1 || id_pc_out !== 32'(4*(i+1)) || id_inst_out !== inst_of(32'(4*(i+1))))
            begin errors++; $display("FAIL b2b_head%0d got %0b/%h/%h exp 1/%h/%h", i, id_valid_out, id_pc_out, id_inst_out, 32'(4*(i+1)), inst_of(32'(4*(i+1)))); end
      end
      id_ready_in = 1'b1;
      @(negedge clk);
      checks++; if (id_pc_out !== 32'h24 || id_inst_out !== inst_of(32'h24)) begin errors++; $display("FAIL b2b_drain1 got %h/%h exp 24/%h", id_pc_out, id_inst_out, inst_of(32'h24)); end
      @(negedge clk);
      id_ready_in = 1'b0;
      checks++; if (id_valid_out !== 1'b0 || stall_or_not !== 1'b1) begin errors++; $display("FAIL b2b_drained got idv %0b stall %0b exp 0/1", id_valid_out, stall_or_not); end
   endtask

   task automatic test_jal();
      logic [31:0] exp_next;
`ifdef IF_JAL_PREDECODE_EN
      exp_next = 32'h30;
`else
      exp_next = 32'h14;
`endif
      do_reset();
      id_ready_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ic_valid_in = 1'b1; ic_inst_in = inst_of(32'(4*k));
         @(negedge clk);
         ic_valid_in = 1'b0;
      end
      @(negedge clk);
      checks++; if (ic_req_out !== 1'b1 || ic_addr_out !== 32'h10) begin errors++; $display("FAIL jal_req got %0b/%h exp 1/10", ic_req_out, ic_addr_out); end
      ic_valid_in = 1'b1; ic_inst_in = 32'h0200_006F;
      @(negedge clk);
      ic_valid_in = 1'b0;
      checks++; if (id_pc_out !== 32'h10 || id_inst_out !== 32'h0200_006F) begin errors++; $display("FAIL jal_push got %h/%h exp 10/0200006f", id_pc_out, id_inst_out); end
      @(negedge clk);
      checks++; if (ic_req_out !== 1'b1 || ic_addr_out !== exp_next) begin errors++; $display("FAIL jal_target got %0b/%h exp 1/%h", ic_req_out, ic_addr_out, exp_next); end
   endtask

   initial begin
      rst = 1'b1; flush_in = 1'b0; flush_pc_in = '0;
      ic_valid_in = 1'b0; ic_inst_in = '0; id_ready_in = 1'b0;
      test_reset();
      test_stream();
      test_full();
      test_flush_wait();
      test_flush_coincident();
      test_back_to_back();
      test_jal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_if_fetch_queue
